operand_collect_stage: RTL and testbench
========================================

// Module: operand_collect_stage
// PURPOSE
//  Single-entry pipeline stage between issue and execute of the OoO backend.
//  Accepts one issued uop and drives its source physical-register read addresses
//  to the PRF and bypass buffer. Captures the registered operand data one cycle later.
//  Operands not ready at issue are collected by snooping writeback ports.
//  The complete uop is presented to execute over a valid/ready handshake.
// PARAMETERS
//  DATA_WIDTH   32  operand width
//  PREG_DEPTH   64  physical registers; ADDR_WIDTH = $clog2(PREG_DEPTH)
//  N_WRITE      2   writeback ports snooped
//  N_SRC        2   source operands per uop
//  PAYLOAD_W    64  opaque uop payload width, passed through unmodified
// PORTS
//  clk          in   1                    clock
//  resetn       in   1                    reset, synchronous, active-low
//  flush        in   1                    pipeline flush, synchronous
//  in_valid     in   1                    issue offers a uop
//  in_ready     out  1                    stage accepts this cycle
//  in_payload   in   PAYLOAD_W            uop payload
//  in_src       in   N_SRC x ADDR_WIDTH   source physical regs
//  in_src_rdy   in   N_SRC                source value already written at issue
//  raddr        out  N_SRC x ADDR_WIDTH   read address to PRF/bypass (= in_src, combinational)
//  rdata        in   N_SRC x DATA_WIDTH   registered read data, valid 1 cycle after raddr
//  wen          in   N_WRITE              writeback enables
//  waddr        in   N_WRITE x ADDR_WIDTH writeback addresses
//  wdata        in   N_WRITE x DATA_WIDTH writeback data
//  out_valid    out  1                    complete uop available
//  out_ready    in   1                    execute consumes
//  out_payload  out  PAYLOAD_W            held payload
//  out_opnd     out  N_SRC x DATA_WIDTH   collected operands
// BEHAVIOUR
//  - States: EMPTY, READ, WAIT, FULL. Every output is registered except in_ready and raddr.
//  - Reset (resetn=0 at posedge): state EMPTY. out_valid=0, out_payload=0, out_opnd=0, all per-src flags=0.
//  - Priority: resetn > flush > normal operation.
//  - Accept: in_ready = !flush && (state==EMPTY || (state==FULL && out_ready)).
//    - Accept fires when in_valid && in_ready at cycle T. Next state is READ.
//    - Latch payload and src addresses.
//    - src_rdy[j] = in_src_rdy[j] OR (any wen[i] && waddr[i]==in_src[j] at T).
//      A write at T is forwarded by the bypass buffer into rdata at T+1.
//  - READ (T+1):
//    - Each src with src_rdy=1: opnd[j] <= rdata[j].
//    - Each src with src_rdy=0 that matches a write at T+1: opnd[j] <= wdata, mark ready.
//    - Next state is FULL if all srcs are ready, else WAIT.
//  - WAIT:
//    - Each cycle, every not-ready src matching a write captures wdata and is marked ready.
//    - Already-ready srcs are never overwritten.
//    - Go to FULL on the cycle after the last operand is captured.
//  - Multiple wen[i] matching one src in the same cycle: highest index i wins.
//  - FULL:
//    - out_valid=1. Payload and operands are held stable while out_ready=0.
//    - out_ready=1 with no accept: next state EMPTY, out_valid=0.
//    - out_ready=1 with in_valid: back-to-back accept, next state READ.
//  - Latency: accept at T -> out_valid at T+2 when all operands are ready at issue.
//    Otherwise out_valid at T+1+(cycles until the last write)+1.
//  - Max throughput: one uop per 2 cycles.
//  - Flush:
//    - Next state EMPTY, out_valid=0 the following cycle; the held uop is dropped.
//    - in_ready=0 during the flush cycle.
//    - Flush in READ discards the incoming rdata.
//  - Reset mid-operation: behaves as flush plus clearing of payload and operands.
//  - raddr follows in_src at all times, independent of in_valid.
// TESTING
//  1. Accept src{5,7} rdy{1,1}; rdata{0x11,0x22} at T+1
//     -> out_valid T+2, out_opnd{0x11,0x22}, payload intact.
//  2. src1=9 rdy=0; wen0 waddr=9 wdata=0xABCD at T+3
//     -> out_valid T+4, out_opnd[1]=0xABCD, opnd[0] from rdata.
//  3. Write to src 9 in the accept cycle T, rdy=0; rdata[1]=0x55 at T+1
//     -> out_opnd[1]=0x55, out_valid T+2.
//  4. wen0/wen1 both to src 9 with 0x1/0x2 in WAIT -> out_opnd=0x2.
//  5. FULL, out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
//     Then out_ready=1 with in_valid -> new uop accepted the same cycle.
//  6. Flush in WAIT -> EMPTY next cycle, out_valid never asserts.
//     resetn=0 in FULL -> out_valid=0, out_opnd=0 next cycle.

Source files
------------

// File: rtl/operand_collect_stage.sv
// Single-entry issue->execute stage: reads source operands from the PRF/bypass,
// snoops writeback ports for late operands and hands the complete uop to execute.
module operand_collect_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PREG_DEPTH = 64,
    parameter int unsigned N_WRITE    = 2,
    parameter int unsigned N_SRC      = 2,
    parameter int unsigned PAYLOAD_W  = 64,
    localparam int unsigned ADDR_WIDTH = $clog2(PREG_DEPTH)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PAYLOAD_W-1:0]          in_payload,
    input  logic [N_SRC*ADDR_WIDTH-1:0]   in_src,
    input  logic [N_SRC-1:0]              in_src_rdy,
    output logic [N_SRC*ADDR_WIDTH-1:0]   raddr,
    input  logic [N_SRC*DATA_WIDTH-1:0]   rdata,
    input  logic [N_WRITE-1:0]            wen,
    input  logic [N_WRITE*ADDR_WIDTH-1:0] waddr,
    input  logic [N_WRITE*DATA_WIDTH-1:0] wdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PAYLOAD_W-1:0]          out_payload,
    output logic [N_SRC*DATA_WIDTH-1:0]   out_opnd
);

    typedef enum logic [1:0] {EMPTY, READ, WAIT, FULL} state_t;

    state_t                               state;
    logic [N_SRC-1:0][ADDR_WIDTH-1:0]     src_q;
    logic [N_SRC-1:0]                     src_rdy;
    logic [N_SRC-1:0][DATA_WIDTH-1:0]     opnd_q;

    logic [N_SRC-1:0][ADDR_WIDTH-1:0]     in_src_a;
    logic [N_SRC-1:0][DATA_WIDTH-1:0]     rdata_a;
    logic [N_WRITE-1:0][ADDR_WIDTH-1:0]   waddr_a;
    logic [N_WRITE-1:0][DATA_WIDTH-1:0]   wdata_a;

    logic [N_SRC-1:0]                     hit_in;
    logic [N_SRC-1:0]                     hit_q;
    logic [N_SRC-1:0][DATA_WIDTH-1:0]     snoop_data;
    logic                                 all_rdy;
    logic                                 accept;

    assign in_src_a = in_src;
    assign rdata_a  = rdata;
    assign waddr_a  = waddr;
    assign wdata_a  = wdata;

    assign raddr    = in_src;
    assign out_opnd = opnd_q;
    assign in_ready = !flush && (state == EMPTY || (state == FULL && out_ready));
    assign accept   = in_valid && in_ready;
    assign all_rdy  = &(src_rdy | hit_q);

    // Writeback snoop; later ports override earlier ones so the highest index wins.
    always_comb begin
        hit_in     = '0;
        hit_q      = '0;
        snoop_data = '0;
        for (int j = 0; j < int'(N_SRC); j++) begin
            for (int i = 0; i < int'(N_WRITE); i++) begin
                if (wen[i] && waddr_a[i] == in_src_a[j]) begin
                    hit_in[j] = 1'b1;
                end
                if (wen[i] && waddr_a[i] == src_q[j]) begin
                    hit_q[j]      = 1'b1;
                    snoop_data[j] = wdata_a[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= EMPTY;
            out_valid   <= 1'b0;
            out_payload <= '0;
            opnd_q      <= '0;
            src_q       <= '0;
            src_rdy     <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            src_rdy   <= '0;
        end else begin
            case (state)
                EMPTY, FULL: begin
                    if (accept) begin
                        // A write seen at accept is forwarded through rdata next cycle.
                        state       <= READ;
                        out_valid   <= 1'b0;
                        out_payload <= in_payload;
                        src_q       <= in_src_a;
                        src_rdy     <= in_src_rdy | hit_in;
                    end else if (state == FULL && out_ready) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                READ: begin
                    for (int j = 0; j < int'(N_SRC); j++) begin
                        if (src_rdy[j]) begin
                            opnd_q[j] <= rdata_a[j];
                        end else if (hit_q[j]) begin
                            opnd_q[j]  <= snoop_data[j];
                            src_rdy[j] <= 1'b1;
                        end
                    end
                    state     <= all_rdy ? FULL : WAIT;
                    out_valid <= all_rdy;
                end
                WAIT: begin
                    for (int j = 0; j < int'(N_SRC); j++) begin
                        if (!src_rdy[j] && hit_q[j]) begin
                            opnd_q[j]  <= snoop_data[j];
                            src_rdy[j] <= 1'b1;
                        end
                    end
                    if (all_rdy) begin
                        state     <= FULL;
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_collect_stage.sv
// Directed bench for operand_collect_stage: vector table for single uops plus
// hand sequences for stall/back-to-back, flush and mid-operation reset.
module tb_operand_collect_stage;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_payload;
    logic [11:0] in_src;
    logic [1:0]  in_src_rdy;
    logic [11:0] raddr;
    logic [63:0] rdata;
    logic [1:0]  wen;
    logic [11:0] waddr;
    logic [63:0] wdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_payload;
    logic [63:0] out_opnd;

    int checks = 0;
    int errors = 0;

    operand_collect_stage dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .in_src      (in_src),
        .in_src_rdy  (in_src_rdy),
        .raddr       (raddr),
        .rdata       (rdata),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload),
        .out_opnd    (out_opnd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pay;
        logic [5:0]  s0, s1;
        logic [1:0]  rdy;
        logic [1:0]  acc_wen;
        logic [5:0]  acc_a0;
        logic [31:0] rd0, rd1;
        int          wr_cyc;
        logic [1:0]  wen;
        logic [5:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [31:0] e0, e1;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_wr(input logic [1:0] en, input logic [5:0] a0, input logic [5:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1);
        wen   = en;
        waddr = {a1, a0};
        wdata = {d1, d0};
    endtask

    task automatic offer(input logic [63:0] pay, input logic [5:0] s0, input logic [5:0] s1,
                         input logic [1:0] rdy);
        in_valid   = 1'b1;
        in_payload = pay;
        in_src     = {s1, s0};
        in_src_rdy = rdy;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        vec_t t;
        int   lat;
        int   cnt;

        //          pay                     s0  s1  rdy    accw   acca rd0           rd1           wc wen    wa0 wa1 wd0           wd1           e0            e1            lat
        vecs[0] = '{64'h1111_0000_0000_0001, 5,  7, 2'b11, 2'b00, 0, 32'h11,       32'h22,       0, 2'b00, 0,  0,  32'h0,        32'h0,        32'h11,       32'h22,       2};
        vecs[1] = '{64'h2222_0000_0000_0002, 5,  9, 2'b01, 2'b00, 0, 32'h33,       32'h77,       3, 2'b01, 9,  0,  32'hABCD,     32'h0,        32'h33,       32'hABCD,     4};
        vecs[2] = '{64'h3333_0000_0000_0003, 5,  9, 2'b01, 2'b01, 9, 32'h44,       32'h55,       0, 2'b00, 0,  0,  32'h0,        32'h0,        32'h44,       32'h55,       2};
        vecs[3] = '{64'h4444_0000_0000_0004, 3,  9, 2'b01, 2'b00, 0, 32'h66,       32'h99,       2, 2'b11, 9,  9,  32'h1,        32'h2,        32'h66,       32'h2,        3};
        vecs[4] = '{64'h5555_0000_0000_0005, 4,  6, 2'b10, 2'b00, 0, 32'hEE,       32'h77,       1, 2'b10, 0,  4,  32'h0,        32'h123,      32'h123,      32'h77,       2};
        vecs[5] = '{64'h6666_0000_0000_0006, 5,  9, 2'b01, 2'b00, 0, 32'h31,       32'h88,       2, 2'b11, 5,  9,  32'hBAD,      32'h42,       32'h31,       32'h42,       3};
        vecs[6] = '{64'h7777_0000_0000_0007, 10, 12, 2'b00, 2'b00, 0, 32'hC0,      32'hC1,       2, 2'b11, 12, 10, 32'hA,        32'hB,        32'hB,        32'hA,        3};

        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_payload = '0; in_src = '0;
        in_src_rdy = '0; rdata = '0; out_ready = 1'b0;
        set_wr(2'b00, 0, 0, 0, 0);
        step(); step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_opnd", out_opnd, 64'd0);
        check("rst_out_payload", out_payload, 64'd0);
        resetn = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        in_src = {6'd33, 6'd17};
        #1;
        check("raddr_follow", 64'(raddr), 64'({6'd33, 6'd17}));

        for (int v = 0; v < 7; v++) begin
            t = vecs[v];
            offer(t.pay, t.s0, t.s1, t.rdy);
            set_wr(t.acc_wen, t.acc_a0, 0, 32'h99, 32'h0);
            #1;
            check($sformatf("v%0d_in_ready", v), 64'(in_ready), 64'd1);
            step();
            in_valid = 1'b0;
            in_src   = {6'd63, 6'd62};
            lat = 0;
            for (int k = 1; k <= 8 && lat == 0; k++) begin
                rdata = (k == 1) ? {t.rd1, t.rd0}
                                 : {32'(32'hDEAD0000 + k), 32'(32'hBEEF0000 + k)};
                if (k == t.wr_cyc) set_wr(t.wen, t.wa0, t.wa1, t.wd0, t.wd1);
                else               set_wr(2'b00, 0, 0, 0, 0);
                step();
                if (out_valid) lat = k + 1;
            end
            set_wr(2'b00, 0, 0, 0, 0);
            check($sformatf("v%0d_latency", v), 64'(lat), 64'(t.lat));
            check($sformatf("v%0d_opnd0", v), 64'(out_opnd[31:0]), 64'(t.e0));
            check($sformatf("v%0d_opnd1", v), 64'(out_opnd[63:32]), 64'(t.e1));
            check($sformatf("v%0d_payload", v), out_payload, t.pay);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check($sformatf("v%0d_drain", v), 64'(out_valid), 64'd0);
        end

        // Stall in FULL, then back-to-back accept.
        offer(64'hA1A1_A1A1_0000_0001, 1, 2, 2'b11);
        step();
        in_valid = 1'b0;
        rdata = {32'h200, 32'h100};
        step();
        rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        offer(64'hB2B2_B2B2_0000_0002, 3, 4, 2'b11);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_opnd", out_opnd, {32'h200, 32'h100});
            check("stall_payload", out_payload, 64'hA1A1_A1A1_0000_0001);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_read_valid", 64'(out_valid), 64'd0);
        rdata = {32'h400, 32'h300};
        step();
        check("b2b_out_valid", 64'(out_valid), 64'd1);
        check("b2b_opnd", out_opnd, {32'h400, 32'h300});
        check("b2b_payload", out_payload, 64'hB2B2_B2B2_0000_0002);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Flush while waiting on an operand.
        offer(64'hC3C3_0000_0000_0003, 5, 9, 2'b01);
        step();
        in_valid = 1'b0;
        rdata = {32'h0, 32'h31};
        step();
        offer(64'hD4D4_0000_0000_0004, 1, 2, 2'b11);
        flush = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        set_wr(2'b01, 9, 0, 32'h77, 32'h0);
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            set_wr(2'b00, 0, 0, 0, 0);
            if (out_valid) cnt++;
        end
        check("flush_never_valid", 64'(cnt), 64'd0);
        check("flush_empty_ready", 64'(in_ready), 64'd1);

        // Reset while holding a complete uop.
        offer(64'hE5E5_0000_0000_0005, 1, 2, 2'b11);
        step();
        in_valid = 1'b0;
        rdata = {32'h2222, 32'h1111};
        step();
        check("prerst_out_valid", 64'(out_valid), 64'd1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_opnd", out_opnd, 64'd0);
        check("midrst_payload", out_payload, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
